// File: rtl/seg7_pkg.sv
// Shared constants for the seven-segment receive path: active-low segment
// codes for each hex digit, the blank separator pattern and the frame FSM
// state type.
package seg7_pkg;

   localparam logic [6:0] SEG7_CODE_0 = 7'h40;
   localparam logic [6:0] SEG7_CODE_1 = 7'h79;
   localparam logic [6:0] SEG7_CODE_2 = 7'h24;
   localparam logic [6:0] SEG7_CODE_3 = 7'h30;
   localparam logic [6:0] SEG7_CODE_4 = 7'h19;
   localparam logic [6:0] SEG7_CODE_5 = 7'h12;
   localparam logic [6:0] SEG7_CODE_6 = 7'h02;
   localparam logic [6:0] SEG7_CODE_7 = 7'h78;
   localparam logic [6:0] SEG7_CODE_8 = 7'h00;
   localparam logic [6:0] SEG7_CODE_9 = 7'h18;
   localparam logic [6:0] SEG7_CODE_A = 7'h08;
   localparam logic [6:0] SEG7_CODE_B = 7'h03;
   localparam logic [6:0] SEG7_CODE_C = 7'h46;
   localparam logic [6:0] SEG7_CODE_D = 7'h21;
   localparam logic [6:0] SEG7_CODE_E = 7'h06;
   localparam logic [6:0] SEG7_CODE_F = 7'h0E;
   localparam logic [6:0] SEG7_BLANK  = 7'h7F;

   // COLLECT: assembling digits; HOLD: complete frame offered downstream.
   typedef enum logic [0:0] {
      ST_COLLECT = 1'b0,
      ST_HOLD    = 1'b1
   } seg7_state_t;

endpackage

// File: rtl/seg7_pattern_decode.sv
// Combinational decode of one active-low segment pattern into a hex nibble.
// Blank is reported separately and never counts as a valid digit.
module seg7_pattern_decode
   import seg7_pkg::*;
(
   input  logic [6:0] seg_in,
   output logic       valid,
   output logic       blank,
   output logic [3:0] nibble
);

   // Pattern lookup; anything outside the 16 codes and blank is invalid.
   always_comb begin
      valid  = 1'b1;
      blank  = 1'b0;
      nibble = 4'h0;
      case (seg_in)
         SEG7_CODE_0: nibble = 4'h0;
         SEG7_CODE_1: nibble = 4'h1;
         SEG7_CODE_2: nibble = 4'h2;
         SEG7_CODE_3: nibble = 4'h3;
         SEG7_CODE_4: nibble = 4'h4;
         SEG7_CODE_5: nibble = 4'h5;
         SEG7_CODE_6: nibble = 4'h6;
         SEG7_CODE_7: nibble = 4'h7;
         SEG7_CODE_8: nibble = 4'h8;
         SEG7_CODE_9: nibble = 4'h9;
         SEG7_CODE_A: nibble = 4'hA;
         SEG7_CODE_B: nibble = 4'hB;
         SEG7_CODE_C: nibble = 4'hC;
         SEG7_CODE_D: nibble = 4'hD;
         SEG7_CODE_E: nibble = 4'hE;
         SEG7_CODE_F: nibble = 4'hF;
         SEG7_BLANK: begin
            valid = 1'b0;
            blank = 1'b1;
         end
         default: begin
            valid = 1'b0;
            blank = 1'b0;
         end
      endcase
   end

endmodule

// File: rtl/seg7_frame_decoder.sv
// Seven-segment frame receiver: debounces strobed active-low segment
// patterns, decodes accepted ones to nibbles and assembles DIGITS nibbles
// (first digit in the most-significant nibble) into a valid/ready frame.
// Optional macro SEG7_DEC_ERR_EN enables the sticky undecodable-pattern flag.
module seg7_frame_decoder
   import seg7_pkg::*;
#(
   parameter int STABLE_CNT = 3,
   parameter int DIGITS     = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [6:0]            seg_in,
   input  logic                  seg_strobe,
   input  logic                  out_ready,
   output logic                  out_valid,
   output logic [4*DIGITS-1:0]   out_value,
   output logic                  out_err
);

   localparam logic [3:0] STAB_C = STABLE_CNT[3:0];
   localparam logic [3:0] DIG_C  = DIGITS[3:0];

   seg7_state_t           state_r;
   logic [6:0]            last_pat_r;
   logic [3:0]            cnt_r;
   logic                  armed_r;
   logic [3:0]            digit_cnt_r;
   logic [4*DIGITS-1:0]   shift_r;
   logic                  out_valid_r;
   logic [4*DIGITS-1:0]   out_value_r;

   logic                  dec_valid_s;
   logic                  dec_blank_s;
   logic [3:0]            dec_nib_s;
   logic                  same_s;
   logic [3:0]            cnt_next_s;
   logic                  accept_s;
   logic                  take_s;
   logic                  done_s;
   logic                  hs_s;
   logic [4*DIGITS+3:0]   shift_wide_s;

   seg7_pattern_decode u_dec (
      .seg_in (seg_in),
      .valid  (dec_valid_s),
      .blank  (dec_blank_s),
      .nibble (dec_nib_s)
   );

   // Stability tracking, one-shot acceptance and shift-in of a new digit.
   always_comb begin
      same_s       = 1'b0;
      cnt_next_s   = cnt_r;
      shift_wide_s = {shift_r, dec_nib_s};
      if (seg_in == last_pat_r) begin
         same_s = 1'b1;
         if (cnt_r >= STAB_C) begin
            cnt_next_s = STAB_C;
         end else begin
            cnt_next_s = cnt_r + 4'd1;
         end
      end else begin
         cnt_next_s = 4'd1;
      end
      // A differing sample rearms, so acceptance only needs the count to land.
      accept_s = seg_strobe && (state_r == ST_COLLECT) &&
                 (cnt_next_s == STAB_C) && (!same_s || armed_r);
      take_s   = accept_s && dec_valid_s && !dec_blank_s;
      done_s   = take_s && ((digit_cnt_r + 4'd1) == DIG_C);
      hs_s     = out_valid_r && out_ready;
   end

   // Frame FSM, stability tracker and digit assembly.
   always_ff @(posedge clk) begin
      if (reset || hs_s) begin
         state_r     <= ST_COLLECT;
         last_pat_r  <= SEG7_BLANK;
         cnt_r       <= 4'd0;
         armed_r     <= 1'b1;
         digit_cnt_r <= 4'd0;
         shift_r     <= '0;
         out_valid_r <= 1'b0;
         out_value_r <= '0;
      end else if ((state_r == ST_COLLECT) && seg_strobe) begin
         cnt_r      <= cnt_next_s;
         last_pat_r <= seg_in;
         if (accept_s) begin
            armed_r <= 1'b0;
         end else if (!same_s) begin
            armed_r <= 1'b1;
         end
         if (take_s) begin
            shift_r     <= shift_wide_s[4*DIGITS-1:0];
            digit_cnt_r <= digit_cnt_r + 4'd1;
            if (done_s) begin
               state_r     <= ST_HOLD;
               out_valid_r <= 1'b1;
               out_value_r <= shift_wide_s[4*DIGITS-1:0];
            end
         end
      end
   end

`ifdef SEG7_DEC_ERR_EN
   logic err_r;
   logic out_err_r;

   // Sticky error for accepted undecodable patterns, latched with the frame.
   always_ff @(posedge clk) begin
      if (reset || hs_s) begin
         err_r     <= 1'b0;
         out_err_r <= 1'b0;
      end else begin
         if (accept_s && !dec_valid_s && !dec_blank_s) begin
            err_r <= 1'b1;
         end
         if (done_s) begin
            out_err_r <= err_r;
         end
      end
   end

   assign out_err = out_err_r;
`else
   assign out_err = 1'b0;
`endif

   assign out_valid = out_valid_r;
   assign out_value = out_value_r;

endmodule

// File: tb/tb_seg7_frame_decoder.sv
// Directed bench for seg7_frame_decoder with STABLE_CNT=3, DIGITS=4.
// Expected out_err follows SEG7_DEC_ERR_EN when the macro is defined.
module tb_seg7_frame_decoder;

   logic        clk;
   logic        reset;
   logic [6:0]  seg_in;
   logic        seg_strobe;
   logic        out_ready;
   logic        out_valid;
   logic [15:0] out_value;
   logic        out_err;

   int tests;
   int fails;

`ifdef SEG7_DEC_ERR_EN
   localparam logic ERR_EXP = 1'b1;
`else
   localparam logic ERR_EXP = 1'b0;
`endif

   seg7_frame_decoder #(.STABLE_CNT(3), .DIGITS(4)) dut (
      .clk        (clk),
      .reset      (reset),
      .seg_in     (seg_in),
      .seg_strobe (seg_strobe),
      .out_ready  (out_ready),
      .out_valid  (out_valid),
      .out_value  (out_value),
      .out_err    (out_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One strobe cycle followed by one idle cycle; returns at a negedge.
   task automatic strobe(input logic [6:0] pat);
      @(negedge clk);
      seg_in     = pat;
      seg_strobe = 1'b1;
      @(negedge clk);
      seg_strobe = 1'b0;
   endtask

   task automatic strobe_n(input logic [6:0] pat, input int n);
      for (int i = 0; i < n; i++) strobe(pat);
   endtask

   task automatic handshake();
      @(negedge clk);
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
   endtask

   initial begin
      tests      = 0;
      fails      = 0;
      reset      = 1'b1;
      seg_in     = 7'h7F;
      seg_strobe = 1'b0;
      out_ready  = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      chk("rst_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_value", {16'd0, out_value}, 32'd0);
      chk("rst_err",   {31'd0, out_err},   32'd0);

      // Frame 1: 2,3,0,F separated by blanks.
      strobe_n(7'h24, 3); strobe(7'h7F);
      strobe_n(7'h30, 3); strobe(7'h7F);
      strobe_n(7'h40, 3); strobe(7'h7F);
      strobe_n(7'h0E, 2);
      chk("f1_not_yet", {31'd0, out_valid}, 32'd0);
      strobe(7'h0E);
      chk("f1_valid", {31'd0, out_valid}, 32'd1);
      chk("f1_value", {16'd0, out_value}, 32'h230F);
      chk("f1_err",   {31'd0, out_err},   32'd0);

      // Held frame ignores strobes while out_ready is low.
      strobe_n(7'h79, 5);
      repeat (10) @(negedge clk);
      chk("hold_valid", {31'd0, out_valid}, 32'd1);
      chk("hold_value", {16'd0, out_value}, 32'h230F);
      handshake();
      chk("hs1_valid_low", {31'd0, out_valid}, 32'd0);

      // Frame 2: glitch rejection, repeat suppression; out_ready held high.
      out_ready = 1'b1;
      strobe(7'h24); strobe(7'h24); strobe(7'h79);
      strobe(7'h24); strobe(7'h24); strobe(7'h24);
      strobe(7'h7F);
      strobe_n(7'h24, 6);
      strobe(7'h7F);
      strobe_n(7'h79, 3);
      chk("f2_partial_valid", {31'd0, out_valid}, 32'd0);
      strobe(7'h7F);
      strobe_n(7'h18, 3);
      chk("f2_valid", {31'd0, out_valid}, 32'd1);
      chk("f2_value", {16'd0, out_value}, 32'h2219);
      @(negedge clk);
      chk("f2_valid_low", {31'd0, out_valid}, 32'd0);
      out_ready = 1'b0;

      // Frame 3: undecodable stable 55 in the middle of the frame.
      strobe_n(7'h24, 3); strobe(7'h7F);
      strobe_n(7'h55, 3); strobe(7'h7F);
      strobe_n(7'h30, 3); strobe(7'h7F);
      strobe_n(7'h40, 3); strobe(7'h7F);
      chk("f3_partial_valid", {31'd0, out_valid}, 32'd0);
      strobe_n(7'h0E, 3);
      chk("f3_valid", {31'd0, out_valid}, 32'd1);
      chk("f3_value", {16'd0, out_value}, 32'h230F);
      chk("f3_err",   {31'd0, out_err},   {31'd0, ERR_EXP});
      handshake();
      chk("hs3_valid_low", {31'd0, out_valid}, 32'd0);
      chk("hs3_err_low",   {31'd0, out_err},   32'd0);

      // Reset after two digits discards the partial frame.
      strobe_n(7'h79, 3); strobe(7'h7F);
      strobe_n(7'h24, 3);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      chk("rst2_valid", {31'd0, out_valid}, 32'd0);
      chk("rst2_value", {16'd0, out_value}, 32'd0);
      chk("rst2_err",   {31'd0, out_err},   32'd0);

      // Frame 4: fresh 9,5,E,b after reset.
      strobe_n(7'h18, 3); strobe(7'h7F);
      strobe_n(7'h12, 3); strobe(7'h7F);
      strobe_n(7'h06, 3); strobe(7'h7F);
      strobe_n(7'h03, 3);
      chk("f4_valid", {31'd0, out_valid}, 32'd1);
      chk("f4_value", {16'd0, out_value}, 32'h95EB);
      chk("f4_err",   {31'd0, out_err},   32'd0);
      handshake();
      chk("hs4_valid_low", {31'd0, out_valid}, 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
